ps2_keypad: RTL and testbench

Converts raw PS/2 scancode bytes from the `ps2in` receiver into the 16-key CHIP-8 keypad matrix and a one-cycle key-event strobe, all in the system `clk` domain. It sits between `ps2in` and `cpu`. It replaces ad-hoc matrix updates clocked by the receiver's ready line. It decodes make/break (`F0`) and extended (`E0`) prefixes, suppresses typematic repeats, and recovers from lost bytes.

---
 rtl/keypad_pkg.sv | 38 +++
 rtl/keypad_map.sv | 40 ++++
 rtl/ps2_keypad.sv | 153 +++++++++++++++
 tb/tb_ps2_keypad.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_pkg
// Description : Shared types and scancode constants for the PS/2 keypad
//               decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

  // Decoder state: which prefix byte (if any) is pending.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } kp_state_t;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_ERR0   = 8'h00;
  localparam logic [7:0] SC_ERR1   = 8'hFF;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_ECHO   = 8'hEE;

  // Keyboard reports an internal error / buffer overrun with these bytes.
  function automatic logic is_error(input logic [7:0] b);
    return (b == SC_ERR0) || (b == SC_ERR1);
  endfunction

  // Protocol housekeeping bytes that carry no key information.
  function automatic logic is_control(input logic [7:0] b);
    return (b == SC_BAT) || (b == SC_ACK) || (b == SC_RESEND) || (b == SC_ECHO);
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_map.sv
`default_nettype none
// ============================================================================
// Module      : keypad_map
// Description : Combinational scancode (set 2) to CHIP-8 key index lookup.
//               Left-hand 4x4 block of a QWERTY keyboard (1234/QWER/ASDF/ZXCV).
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_map (
  input  logic [7:0] code,
  output logic       valid,
  output logic [3:0] index
);

  // Table lookup; anything not in the 4x4 block is reported as unmapped.
  always_comb begin
    valid = 1'b1;
    index = 4'h0;
    case (code)
      8'h16: index = 4'h1;
      8'h1E: index = 4'h2;
      8'h26: index = 4'h3;
      8'h25: index = 4'hC;
      8'h15: index = 4'h4;
      8'h1D: index = 4'h5;
      8'h24: index = 4'h6;
      8'h2D: index = 4'hD;
      8'h1C: index = 4'h7;
      8'h1B: index = 4'h8;
      8'h23: index = 4'h9;
      8'h2B: index = 4'hE;
      8'h1A: index = 4'hA;
      8'h22: index = 4'h0;
      8'h21: index = 4'hB;
      8'h2A: index = 4'hF;
      default: valid = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ps2_keypad.sv
`default_nettype none
// ============================================================================
// Module      : ps2_keypad
// Description : PS/2 scancode stream to 16-key CHIP-8 keypad matrix with
//               make/break/extended decoding, typematic suppression, error
//               recovery and prefix timeout. Single clock domain (clk).
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_keypad
  import keypad_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_ready,
  input  logic [7:0]  ps2_data,
  output logic [15:0] keyMatrix,
  output logic        key_event,
  output logic [3:0]  key_code,
  output logic        key_down,
  output logic        overrun
);

  localparam logic [17:0] c_timeout = 18'(TIMEOUT_CYCLES);

  logic        r_s1, r_s2, r_s3;
  logic        w_strobe;
  kp_state_t   r_state, w_state_next;
  logic [17:0] r_cnt;
  logic        w_timeout;
  logic        w_map_valid;
  logic [3:0]  w_map_index;

  logic [15:0] r_matrix, w_matrix_next;
  logic        r_event, w_event_next;
  logic [3:0]  r_code, w_code_next;
  logic        r_down, w_down_next;
  logic        r_overrun, w_overrun_next;

  keypad_map u_map (
    .code  (ps2_data),
    .valid (w_map_valid),
    .index (w_map_index)
  );

  // Two-flop synchronizer plus history flop for rising-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= ps2_ready;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // ps2_data is held stable while ps2_ready is high, so it is safe to use raw.
  assign w_strobe  = r_s2 & ~r_s3;
  assign w_timeout = (r_cnt >= c_timeout);

  // Prefix timeout: counts only while a prefix is pending, saturates at max.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_strobe || (r_state == ST_IDLE)) begin
      r_cnt <= '0;
    end else if (r_cnt != '1) begin
      r_cnt <= r_cnt + 18'd1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_matrix  <= '0;
      r_event   <= 1'b0;
      r_code    <= '0;
      r_down    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_matrix  <= w_matrix_next;
      r_event   <= w_event_next;
      r_code    <= w_code_next;
      r_down    <= w_down_next;
      r_overrun <= w_overrun_next;
    end
  end

  // Byte decode: a received byte always wins over a coincident timeout.
  always_comb begin
    w_state_next   = r_state;
    w_matrix_next  = r_matrix;
    w_event_next   = 1'b0;
    w_code_next    = r_code;
    w_down_next    = r_down;
    w_overrun_next = r_overrun;

    if (w_strobe) begin
      if (is_error(ps2_data)) begin
        // Key state is unknowable after an overrun; drop everything silently.
        w_matrix_next  = '0;
        w_overrun_next = 1'b1;
        w_state_next   = ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (ps2_data == SC_BREAK) begin
              w_state_next = ST_BRK;
            end else if (ps2_data == SC_EXT) begin
              w_state_next = ST_EXT;
            end else if (!is_control(ps2_data) && w_map_valid &&
                         !r_matrix[w_map_index]) begin
              w_matrix_next[w_map_index] = 1'b1;
              w_event_next               = 1'b1;
              w_code_next                = w_map_index;
              w_down_next                = 1'b1;
            end
          end
          ST_BRK: begin
            w_state_next = ST_IDLE;
            if (w_map_valid && r_matrix[w_map_index]) begin
              w_matrix_next[w_map_index] = 1'b0;
              w_event_next               = 1'b1;
              w_code_next                = w_map_index;
              w_down_next                = 1'b0;
            end
          end
          ST_EXT: begin
            w_state_next = (ps2_data == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
          end
          default: begin
            w_state_next = ST_IDLE;
          end
        endcase
      end
    end else if ((r_state != ST_IDLE) && w_timeout) begin
      w_state_next = ST_IDLE;
    end
  end

  assign keyMatrix = r_matrix;
  assign key_event = r_event;
  assign key_code  = r_code;
  assign key_down  = r_down;
  assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_ps2_keypad.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_keypad
// Description : Self-checking bench for ps2_keypad. A behavioural model
//               tracks the keypad from the byte stream; a negedge process
//               compares every output every cycle, and directed scenarios add
//               hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_keypad;

  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        ps2_ready;
  logic [7:0]  ps2_data;
  logic [15:0] keyMatrix;
  logic        key_event;
  logic [3:0]  key_code;
  logic        key_down;
  logic        overrun;

  ps2_keypad #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_ready (ps2_ready),
    .ps2_data  (ps2_data),
    .keyMatrix (keyMatrix),
    .key_event (key_event),
    .key_code  (key_code),
    .key_down  (key_down),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int ev_count = 0;
  bit cmp_en = 1'b0;

  always @(posedge clk) cyc++;

  // ---------------- behavioural model ----------------
  logic [7:0]  kmap [16];          // scancode of CHIP-8 key n
  logic [15:0] m_matrix;
  logic        m_event;
  logic [3:0]  m_code;
  logic        m_down;
  logic        m_overrun;
  int          m_prefix;           // 0 none, 1 break, 2 ext, 3 ext+break
  int          m_prefix_cyc;

  function automatic int key_of(input logic [7:0] b);
    for (int i = 0; i < 16; i++) if (kmap[i] == b) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_matrix = '0; m_event = 1'b0; m_code = '0; m_down = 1'b0;
    m_overrun = 1'b0; m_prefix = 0; m_prefix_cyc = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int k;
    k = key_of(b);
    if (m_prefix != 0 && (cyc - m_prefix_cyc) > TMO + 1) m_prefix = 0;
    if (b == 8'h00 || b == 8'hFF) begin
      m_matrix = '0; m_overrun = 1'b1; m_prefix = 0;
    end else if (m_prefix == 0) begin
      if (b == 8'hF0) begin m_prefix = 1; m_prefix_cyc = cyc; end
      else if (b == 8'hE0) begin m_prefix = 2; m_prefix_cyc = cyc; end
      else if (k >= 0 && m_matrix[k] == 1'b0) begin
        m_matrix[k] = 1'b1; m_event = 1'b1; m_code = 4'(k); m_down = 1'b1;
      end
    end else if (m_prefix == 1) begin
      m_prefix = 0;
      if (k >= 0 && m_matrix[k] == 1'b1) begin
        m_matrix[k] = 1'b0; m_event = 1'b1; m_code = 4'(k); m_down = 1'b0;
      end
    end else if (m_prefix == 2) begin
      if (b == 8'hF0) begin m_prefix = 3; m_prefix_cyc = cyc; end
      else m_prefix = 0;
    end else begin
      m_prefix = 0;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_matrix",  32'(keyMatrix), 32'(m_matrix));
      check("cyc_event",   32'(key_event), 32'(m_event));
      check("cyc_code",    32'(key_code),  32'(m_code));
      check("cyc_down",    32'(key_down),  32'(m_down));
      check("cyc_overrun", 32'(overrun),   32'(m_overrun));
      if (key_event === 1'b1) ev_count++;
    end
  end

  // ---------------- stimulus ----------------
  // Ready rises after a negedge; first sampled at edge k, outputs change at k+2.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    ps2_ready = 1'b1; ps2_data = b;
    @(posedge clk);                 // k
    @(posedge clk);                 // k+1
    @(posedge clk); #1;             // k+2
    model_byte(b);
    @(posedge clk); #1;             // k+3
    m_event = 1'b0;
    @(negedge clk);
    ps2_ready = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  int ev0;

  initial begin
    kmap = '{8'h22, 8'h16, 8'h1E, 8'h26, 8'h15, 8'h1D, 8'h24, 8'h1C,
             8'h1B, 8'h23, 8'h1A, 8'h21, 8'h25, 8'h2D, 8'h2B, 8'h2A};
    reset = 1'b1; ps2_ready = 1'b0; ps2_data = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    @(negedge clk);
    check("reset_matrix",  32'(keyMatrix), 32'h0);
    check("reset_overrun", 32'(overrun),   32'h0);
    reset = 1'b0;

    // Press / release of key 7
    ev0 = ev_count;
    send(8'h1C);
    check("press7_matrix", 32'(keyMatrix), 32'h0080);
    check("press7_code",   32'(key_code),  32'h7);
    check("press7_down",   32'(key_down),  32'h1);
    send(8'hF0); send(8'h1C);
    check("rel7_matrix", 32'(keyMatrix), 32'h0000);
    check("rel7_down",   32'(key_down),  32'h0);
    check("rel7_events", 32'(ev_count - ev0), 32'd2);

    // Typematic repeat on key 0
    ev0 = ev_count;
    send(8'h22);
    check("typ_matrix", 32'(keyMatrix), 32'h0001);
    send(8'h22); send(8'h22);
    check("typ_matrix2", 32'(keyMatrix), 32'h0001);
    send(8'hF0); send(8'h22);
    check("typ_events", 32'(ev_count - ev0), 32'd2);
    check("typ_final",  32'(keyMatrix), 32'h0000);

    // Extended, unmapped and control bytes
    ev0 = ev_count;
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'h34);
    send(8'hAA); send(8'hFA);
    check("ext_matrix", 32'(keyMatrix), 32'h0);
    check("ext_events", 32'(ev_count - ev0), 32'd0);
    send(8'hE0); send(8'h16);       // extended 16 is not key 1
    check("ext16_matrix", 32'(keyMatrix), 32'h0);

    // Error recovery
    send(8'h16); send(8'h2A);
    check("err_pre_matrix", 32'(keyMatrix), 32'h8002);
    ev0 = ev_count;
    send(8'h00);
    check("err_matrix",  32'(keyMatrix), 32'h0);
    check("err_overrun", 32'(overrun),   32'h1);
    check("err_events",  32'(ev_count - ev0), 32'd0);
    send(8'h16);
    check("err_after_matrix", 32'(keyMatrix), 32'h0002);
    check("err_after_events", 32'(ev_count - ev0), 32'd1);
    send(8'hF0); send(8'hFF);       // error byte also cancels a prefix
    check("err2_matrix", 32'(keyMatrix), 32'h0);
    send(8'h1A);
    check("err2_pressA", 32'(keyMatrix), 32'h0400);
    send(8'hF0); send(8'h1A);
    check("err2_relA", 32'(keyMatrix), 32'h0);

    // Prefix timeout
    send(8'hF0);
    wait_cycles(TMO + 5);
    send(8'h1A);
    check("tmo_matrix", 32'(keyMatrix), 32'h0400);
    check("tmo_down",   32'(key_down),  32'h1);

    // Reset while a break prefix is pending
    send(8'hF0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    model_reset();
    @(negedge clk);
    check("rst_matrix",  32'(keyMatrix), 32'h0);
    check("rst_overrun", 32'(overrun),   32'h0);
    check("rst_code",    32'(key_code),  32'h0);
    reset = 1'b0;
    send(8'h16);
    check("rst_after_matrix", 32'(keyMatrix), 32'h0002);
    check("rst_after_down",   32'(key_down),  32'h1);
    check("rst_after_code",   32'(key_code),  32'h1);

    wait_cycles(4);
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
